// File: rtl/eth_buf_pkg.sv
// Shared types for the Ethernet frame buffer: read-side state and the frame length type.
package eth_buf_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RD   = 1'b1
  } rd_state_e;

  localparam int ADDR_WIDTH_DEF = 11;

  // Frame length at the default RAM size; a frame is 1..2**ADDR_WIDTH-1 bytes.
  typedef logic [ADDR_WIDTH_DEF-1:0] len_t;

endpackage

// File: rtl/frame_len_fifo.sv
// Register-based synchronous FIFO holding lengths of committed frames awaiting readout.
module frame_len_fifo #(
  parameter int WIDTH     = 11,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_LOG:0]   count_o
);
  localparam int DEPTH = 2**DEPTH_LOG;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]   count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
    end
  end

endmodule

// File: rtl/eth_pkt_buf.sv
// Frame buffer controller: speculative frame writes on RAM port A, committed frames
// streamed out of port B through a 2-entry skid buffer; bad or oversize frames are rewound.
module eth_pkt_buf
  import eth_buf_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_DEPTH_LOG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_d,
  input  logic                     in_v,
  input  logic                     in_last,
  input  logic                     in_err,
  output logic [DATA_WIDTH-1:0]    out_d,
  output logic                     out_v,
  output logic                     out_last,
  input  logic                     out_rdy,
  output logic                     drop,
  output logic [LEN_DEPTH_LOG:0]   frames,
  output logic [ADDR_WIDTH-1:0]    ram_a_a,
  output logic [DATA_WIDTH-1:0]    ram_d_a,
  output logic                     ram_w_a,
  input  logic [DATA_WIDTH-1:0]    ram_q_a,
  output logic [ADDR_WIDTH-1:0]    ram_a_b,
  output logic [DATA_WIDTH-1:0]    ram_d_b,
  output logic                     ram_w_b,
  input  logic [DATA_WIDTH-1:0]    ram_q_b
);
  localparam int FW = LEN_DEPTH_LOG + 1;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  localparam ptr_t PTR_MAX = '1;

  ptr_t wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d, rcnt_q, rcnt_d, cnt_eff;
  logic dropping_q, dropping_d, mid_q, mid_d, drop_q, drop_d;
  logic [FW-1:0] frames_q, frames_d;
  rd_state_e state_q, state_d;
  logic pend_q, pend_last_q;
  logic out_v_q, out_v_d, out_last_q, out_last_d, skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0] out_d_q, out_d_d, skid_d_q, skid_d_d;
  logic wr_en, drop_now, ram_full, xfer, room, issue, issue_last;
  logic [2:0] after_n;
  logic len_push, len_pop, len_full, len_empty;
  ptr_t len_wdata, len_rdata;
  logic [FW-1:0] len_count;
  logic unused_ok;

  frame_len_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH_LOG(LEN_DEPTH_LOG)) u_len_fifo (
    .clk(clk), .rst(rst), .push_i(len_push), .pop_i(len_pop), .wdata_i(len_wdata),
    .rdata_o(len_rdata), .full_o(len_full), .empty_o(len_empty), .count_o(len_count)
  );

  assign ram_full = ((wptr_q - rptr_q) == PTR_MAX);

  always_comb begin
    wptr_d = wptr_q; cptr_d = cptr_q; dropping_d = dropping_q; mid_d = mid_q;
    drop_d = 1'b0; drop_now = 1'b0; wr_en = 1'b0; len_push = 1'b0;
    len_wdata = wptr_q + 1'b1 - cptr_q;
    if (in_v) begin
      mid_d    = ~in_last;
      drop_now = dropping_q | (~mid_q & len_full) | ram_full | (in_last & in_err);
      if (!drop_now) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
      end
      // Frame end: either rewind to the last commit point or publish the frame.
      if (in_last) begin
        if (drop_now) begin
          wptr_d = cptr_q; drop_d = 1'b1; dropping_d = 1'b0;
        end else begin
          cptr_d = wptr_q + 1'b1; len_push = 1'b1;
        end
      end else if (drop_now) begin
        dropping_d = 1'b1;
      end
    end
  end

  // A read may issue only if its data will find a free slot when it lands.
  assign xfer    = out_v_q & out_rdy;
  assign after_n = 3'(out_v_q) + 3'(skid_v_q) + 3'(pend_q) - 3'(xfer);
  assign room    = (after_n <= 3'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= R_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      R_IDLE: if (!len_empty) begin
        state_d = issue_last ? R_IDLE : R_RD;
        rcnt_d  = issue ? cnt_eff - 1'b1 : cnt_eff;
      end
      R_RD: if (issue) begin
        rcnt_d = cnt_eff - 1'b1;
        if (issue_last) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    len_pop = 1'b0; issue = 1'b0; cnt_eff = rcnt_q;
    case (state_q)
      R_IDLE: if (!len_empty) begin
        len_pop = 1'b1; cnt_eff = len_rdata; issue = room;
      end
      R_RD:    issue = room;
      default: issue = 1'b0;
    endcase
    issue_last = issue & (cnt_eff == ptr_t'(1));
  end

  assign rptr_d = issue ? rptr_q + 1'b1 : rptr_q;

  always_comb begin
    out_v_d = out_v_q; out_d_d = out_d_q; out_last_d = out_last_q;
    skid_v_d = skid_v_q; skid_d_d = skid_d_q; skid_last_d = skid_last_q;
    if (xfer) begin
      out_v_d = skid_v_q; out_d_d = skid_d_q; out_last_d = skid_last_q; skid_v_d = 1'b0;
    end
    if (pend_q) begin
      if (!out_v_d) begin
        out_v_d = 1'b1; out_d_d = ram_q_b; out_last_d = pend_last_q;
      end else begin
        skid_v_d = 1'b1; skid_d_d = ram_q_b; skid_last_d = pend_last_q;
      end
    end
  end

  assign frames_d = frames_q + FW'(len_push) - FW'(xfer & out_last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0; cptr_q <= '0; rptr_q <= '0; rcnt_q <= '0;
      dropping_q <= 1'b0; mid_q <= 1'b0; drop_q <= 1'b0; frames_q <= '0;
      pend_q <= 1'b0; pend_last_q <= 1'b0;
      out_v_q <= 1'b0; out_d_q <= '0; out_last_q <= 1'b0;
      skid_v_q <= 1'b0; skid_d_q <= '0; skid_last_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d; cptr_q <= cptr_d; rptr_q <= rptr_d; rcnt_q <= rcnt_d;
      dropping_q <= dropping_d; mid_q <= mid_d; drop_q <= drop_d; frames_q <= frames_d;
      pend_q <= issue; pend_last_q <= issue_last;
      out_v_q <= out_v_d; out_d_q <= out_d_d; out_last_q <= out_last_d;
      skid_v_q <= skid_v_d; skid_d_q <= skid_d_d; skid_last_q <= skid_last_d;
    end
  end

  assign out_d    = out_d_q;
  assign out_v    = out_v_q;
  assign out_last = out_last_q;
  assign drop     = drop_q;
  assign frames   = frames_q;
  assign ram_a_a  = wptr_q;
  assign ram_d_a  = in_d;
  assign ram_w_a  = wr_en & ~rst;
  assign ram_a_b  = rptr_q;
  assign ram_d_b  = '0;
  assign ram_w_b  = 1'b0;
  assign unused_ok = ^{ram_q_a, len_count};

endmodule

// File: tb/tb_eth_pkt_buf.sv
// Scoreboard bench for eth_pkt_buf on a small RAM: frame-level reference model, decoupled monitor.
module tb_eth_pkt_buf;
  localparam int AW = 4, DW = 8, LDL = 2;
  localparam int CAP = 2**AW - 1;
  localparam int NLEN = 2**LDL;

  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] in_d = '0, out_d, ram_d_a, ram_q_a, ram_d_b, ram_q_b;
  logic in_v = 1'b0, in_last = 1'b0, in_err = 1'b0, out_v, out_last, out_rdy = 1'b0, drop;
  logic ram_w_a, ram_w_b;
  logic [LDL:0] frames;
  logic [AW-1:0] ram_a_a, ram_a_b;

  always #5 clk = ~clk;

  eth_pkt_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_DEPTH_LOG(LDL)) dut (
    .clk(clk), .rst(rst), .in_d(in_d), .in_v(in_v), .in_last(in_last), .in_err(in_err),
    .out_d(out_d), .out_v(out_v), .out_last(out_last), .out_rdy(out_rdy), .drop(drop),
    .frames(frames), .ram_a_a(ram_a_a), .ram_d_a(ram_d_a), .ram_w_a(ram_w_a),
    .ram_q_a(ram_q_a), .ram_a_b(ram_a_b), .ram_d_b(ram_d_b), .ram_w_b(ram_w_b),
    .ram_q_b(ram_q_b)
  );

  // Dual-port RAM with registered read (old data on collision).
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_w_a) mem[ram_a_a] <= ram_d_a;
    ram_q_a <= mem[ram_a_a];
    ram_q_b <= mem[ram_a_b];
  end

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   checks = 0, errors = 0, drop_seen = 0, drop_exp = 0, cyc = 0, last_cyc = 0;
  int   rdy_mode = 0, pat_i = 0;
  logic rdy_fix = 1'b0;
  bit   pat [6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_rdy = rdy_fix;
        1: out_rdy = 1'($urandom_range(0, 1));
        default: begin out_rdy = pat[pat_i % 6]; pat_i++; end
      endcase
    end
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer and checks hold-while-stalled.
  logic prev_stall = 1'b0, prev_last;
  logic [DW-1:0] prev_d;
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (drop) drop_seen++;
      if (prev_stall) begin
        checks++;
        if (!out_v || out_d !== prev_d || out_last !== prev_last) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", out_v, out_d, out_last, prev_d, prev_last);
        end
      end
      if (out_v && out_rdy) begin
        exp_t e;
        xfer_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer: got unexpected byte d=%h l=%b, expected none", out_d, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_d !== e.d || out_last !== e.l) begin
            errors++;
            $display("FAIL xfer: got d=%h l=%b expected d=%h l=%b", out_d, out_last, e.d, e.l);
          end else
            $display("xfer cyc=%0d d=%h last=%b", cyc, out_d, out_last);
        end
      end
      prev_stall = out_v && !out_rdy; prev_d = out_d; prev_last = out_last;
    end
  end

  function automatic int lasts();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].l) n++;
    return n;
  endfunction

  task automatic send_frame(input logic [DW-1:0] fr[$], input bit err, input bit commit,
                            input bit gaps, input bit no_last);
    if (commit) foreach (fr[i]) exp_q.push_back({fr[i], 1'(i == fr.size() - 1)});
    else if (!no_last) drop_exp++;
    foreach (fr[i]) begin
      in_d = fr[i]; in_v = 1'b1;
      in_last = (i == fr.size() - 1) && !no_last;
      in_err = in_last && err;
      if (in_last) last_cyc = cyc;
      @(posedge clk); #1;
      in_v = 1'b0; in_last = 1'b0; in_err = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    repeat (6) @(negedge clk);
    check({tag, " frames"}, int'(frames), lasts());
    check({tag, " drops"}, drop_seen, drop_exp);
  endtask

  task automatic wait_space(input int len);
    int i;
    for (i = 0; i < 500 && (exp_q.size() + len > CAP || lasts() >= NLEN); i++) @(posedge clk);
    #1;
    if (i == 500) check("space_timeout", 1, 0);
  endtask

  function automatic void mk(output logic [DW-1:0] fr[$], input int n, input int base, input int step);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(DW'(base + i * step));
  endfunction

  logic [DW-1:0] fr[$];
  int first_cyc, found, k;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst out_v", out_v, 0); check("rst out_last", out_last, 0);
    check("rst out_d", out_d, 0); check("rst drop", drop, 0);
    check("rst frames", frames, 0); check("rst ram_w_a", ram_w_a, 0);

    // 1: latency and streaming of 01..04
    rdy_fix = 1'b1; xfer_cyc.delete();
    mk(fr, 4, 1, 1); send_frame(fr, 0, 1, 0, 0);
    @(negedge clk);
    check("t1 frames+1", frames, 1);
    found = 0; first_cyc = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      if (out_v) begin found = 1; first_cyc = cyc; end
      else @(negedge clk);
    end
    check("t1 latency", first_cyc - last_cyc, 3);
    settle();
    check("t1 nxfer", xfer_cyc.size(), 4);
    if (xfer_cyc.size() == 4) check("t1 consecutive", xfer_cyc[3] - xfer_cyc[0], 3);
    check("t1 frames0", frames, 0);

    // 2: errored frame discarded, next frame written from address 0
    do_reset();
    fr = '{8'hAA, 8'hBB, 8'hCC}; send_frame(fr, 1, 0, 0, 0);
    fr = '{8'h11, 8'h22};        send_frame(fr, 0, 1, 0, 0);
    settle();
    check("t2 drops", drop_seen, drop_exp);
    check("t2 mem0", mem[0], 8'h11); check("t2 mem1", mem[1], 8'h22);

    // 3: stalled readout with ready pattern
    rdy_mode = 2;
    mk(fr, 5, 8'h30, 1); send_frame(fr, 0, 1, 0, 0);
    mk(fr, 5, 8'h40, 1); send_frame(fr, 0, 1, 0, 0);
    settle(); rdy_mode = 0;

    // 4: capacity limits with readout stalled
    do_reset(); rdy_fix = 1'b0;
    mk(fr, 20, 1, 1);  send_frame(fr, 0, 0, 0, 0); check_state("t4a");
    mk(fr, CAP, 8'h60, 1); send_frame(fr, 0, 1, 0, 0); check_state("t4b");
    mk(fr, 3, 8'h90, 1); send_frame(fr, 0, 0, 0, 0); check_state("t4c");
    rdy_fix = 1'b1; settle();
    mk(fr, CAP + 1, 8'hA0, 1); send_frame(fr, 0, 0, 0, 0); check_state("t4d");

    // Length FIFO full: skid holds two frames, FSM holds one, FIFO holds the rest
    rdy_fix = 1'b0;
    for (int f = 0; f < NLEN + 4; f++) begin
      fr = '{DW'(8'hC0 + f)};
      send_frame(fr, 0, (f < NLEN + 3), 0, 0);
      repeat (4) @(posedge clk); #1;
    end
    check_state("lenfull");
    rdy_fix = 1'b1; settle();

    // 5: pointer wrap with 10-byte frames
    k = 0;
    for (int f = 0; f < 12; f++) begin
      wait_space(10);
      mk(fr, 10, k, 1); k += 10;
      send_frame(fr, 0, 1, 0, 0);
    end
    settle(); check_state("t5");

    // 6: reset mid-frame and mid-readout
    rdy_fix = 1'b0;
    mk(fr, 10, 8'h70, 1); send_frame(fr, 0, 1, 0, 0);
    mk(fr, 3, 8'hE0, 1);  send_frame(fr, 0, 0, 0, 1);
    rdy_fix = 1'b1; repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("t6 out_v", out_v, 0); check("t6 frames", frames, 0);
    fr = '{8'h5A}; send_frame(fr, 0, 1, 0, 0);
    settle();
    check("t6 mem0", mem[0], 8'h5A);

    // Random frames, random gaps and ready
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len; bit err;
      len = $urandom_range(1, 12); err = ($urandom_range(0, 3) == 0);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(DW'($urandom));
      wait_space(len);
      send_frame(fr, err, !err, 1, 0);
    end
    settle(); check_state("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_pkt_buf.md
Name: eth_pkt_buf

Overview:
- Frame buffer controller that drives the system side of a true dual-port single-clock RAM (byte-wide, 1-cycle registered read).
- Port A writes incoming Ethernet frame bytes; port B reads committed frames out under valid/ready.
- Frames ending in error, or overflowing the buffer, are discarded by rewinding the write pointer, so downstream only ever sees complete good frames.

Parameters:
- ADDR_WIDTH, 11, RAM address width; capacity is 2**ADDR_WIDTH-1 bytes.
- DATA_WIDTH, 8, byte width; must match the RAM.
- LEN_DEPTH_LOG, 4, log2 of the committed-frame length FIFO depth (16 frames).

Ports:
- clk  in  1  system clock, shared with the RAM
- rst  in  1  synchronous active-high reset
- in_d  in  DATA_WIDTH  input byte
- in_v  in  1  input byte valid (no backpressure)
- in_last  in  1  last byte of frame, qualified by in_v
- in_err  in  1  frame bad, qualified by in_v & in_last
- out_d  out  DATA_WIDTH  output byte
- out_v  out  1  output valid
- out_last  out  1  last byte of frame
- out_rdy  in  1  downstream ready
- drop  out  1  one-cycle pulse when a frame is discarded
- frames  out  LEN_DEPTH_LOG+1  committed frames not yet fully popped
- ram_a_a  out  ADDR_WIDTH  port A address
- ram_d_a  out  DATA_WIDTH  port A write data
- ram_w_a  out  1  port A write enable
- ram_q_a  in  DATA_WIDTH  unused
- ram_a_b  out  ADDR_WIDTH  port B address
- ram_d_b  out  DATA_WIDTH  tied 0
- ram_w_b  out  1  tied 0
- ram_q_b  in  DATA_WIDTH  port B read data, valid 1 cycle after the address

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: wptr, cptr and rptr are 0; length FIFO is empty; out_v=0, out_last=0, out_d=0, drop=0, frames=0, ram_w_a=0. A frame in progress is lost and RAM contents are not cleared.
- Write side, speculative:
  - used = wptr - rptr (mod 2**ADDR_WIDTH); full when used == 2**ADDR_WIDTH-1.
  - An accepted byte writes at wptr (ram_w_a=1 in the same cycle) and increments wptr with wrap.
- Drop conditions, all mid-frame: first byte while the length FIFO is full; any byte while full; or in_err at in_last.
  - On a drop condition, set the dropping flag and write nothing further.
  - At in_last: wptr<=cptr, drop=1 for one cycle, dropping cleared.
- Commit: in_last, no error, not dropping.
  - Write the last byte and set cptr<=wptr+1.
  - Push the frame length (1..2**ADDR_WIDTH-1) into the length FIFO.
- Read FSM:
  - R_IDLE: when the length FIFO is non-empty, pop it, load rcnt=len, go to R_RD.
  - R_RD: issue a read at rptr (rptr++) whenever the 2-entry output skid buffer will have room. The last issue tags last=1 and goes to R_IDLE.
- Freed space: rptr advances on issue, so space is freed at issue. A port A write to that address can occur no earlier than the next cycle, so there is no same-address read/write conflict.
- Latency, output idle:
  - in_last sampled in cycle N; frames increments at N+1, where the FSM also pops and issues.
  - ram_q_b is valid at N+2; out_v=1 at N+3.
  - Sustained throughput is 1 byte/cycle with out_rdy=1.
- Back-to-back frames: the FSM may pop the next length in the cycle after the final issue, with no bubble requirement beyond one cycle.
- Handshake: out_d, out_v and out_last stay stable while out_v & !out_rdy. A transfer happens on out_v & out_rdy.
- frames: +1 on commit, -1 when out_last transfers; a simultaneous commit and out_last transfer leaves it unchanged.
- Commit and pop of the length FIFO in the same cycle are legal.

Decomposition:
- Package eth_buf_pkg holds the read-state enum (R_IDLE, R_RD) and the length type, sized ADDR_WIDTH.
- Sub-module frame_len_fifo: register-based sync FIFO of depth 2**LEN_DEPTH_LOG with push, pop, full, empty and a count output.
- The skid buffer stays inline.

Test Plan:
- Frame 01 02 03 04, out_rdy=1 -> out_d 01,02,03,04 on consecutive cycles; out_last with 04; out_v first high 3 cycles after in_last; frames 1 then 0.
- Frame AA BB CC with in_err at last, then good frame 11 22 -> drop pulses once; only 11 22 output; wptr rewound (second frame reads from address 0).
- Two frames of 5 bytes, out_rdy pattern 1,0,0,1,0,1... -> all 10 bytes in order, no duplicates; out_d held while stalled; out_last on bytes 5 and 10.
- ADDR_WIDTH=4, out_rdy=0: 20-byte frame -> drop pulse at in_last, frames=0; then 15-byte frame accepted, frames=1; 16th byte of any frame triggers drop.
- ADDR_WIDTH=4: 12 frames of 10 bytes with incrementing data, out_rdy=1 -> pointers wrap repeatedly and all data matches.
- Assert rst mid-frame (3 bytes written) and mid-readout -> next cycle out_v=0, frames=0; next frame 5A output correctly from address 0.
